lsu_stage: RTL and testbench

- Load/store unit directly downstream of the ALU in the RV32I core. It consumes the ALU result as the effective address and performs one data-memory access per instruction over a req/gnt/rvalid handshake.
- Loads are byte/half/word with sign or zero extension; stores use byte enables.
- The result goes to writeback as a single-cycle wb_valid pulse.

---
 rtl/lsu_stage.sv | 213 +++++++++++++++++++++
 tb/tb_lsu_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_stage.sv
// Load/store stage: one data-memory access per instruction over req/gnt/rvalid, with a
// bypass path for non-memory ops. Define LSU_MISALIGN_TRAP_EN to trap misaligned H/W accesses.
module lsu_stage #(
  parameter int unsigned TIMEOUT       = 255,
  parameter bit          BYPASS_NONMEM = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ex_valid_i,
  output logic        ex_ready_o,
  input  logic [1:0]  ex_memop_i,
  input  logic [2:0]  ex_funct3_i,
  input  logic [31:0] ex_addr_i,
  input  logic [31:0] ex_wdata_i,
  input  logic [4:0]  ex_rd_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [3:0]  dmem_be_o,
  output logic [31:0] dmem_addr_o,
  output logic [31:0] dmem_wdata_o,
  input  logic        dmem_gnt_i,
  input  logic        dmem_rvalid_i,
  input  logic [31:0] dmem_rdata_i,
  output logic        wb_valid_o,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  output logic        lsu_err_o,
  output logic [31:0] lsu_err_addr_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWaitR, StResp} state_e;

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [4:0]  rd_q, rd_d;
  logic        wb_valid_q, wb_valid_d;
  logic [4:0]  wb_rd_q, wb_rd_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;
  logic [31:0] err_addr_q, err_addr_d;

  logic        is_load, is_store, is_mem, f3_rsvd, misalign;
  logic [3:0]  lane_be;
  logic [31:0] lane_wdata;
  logic [7:0]  rd_byte;
  logic [15:0] rd_half;
  logic [31:0] load_data;

  assign is_load  = (ex_memop_i == 2'b01);
  assign is_store = (ex_memop_i == 2'b10);
  assign is_mem   = is_load | is_store;
  assign f3_rsvd  = (ex_funct3_i == 3'b011) || (ex_funct3_i[2:1] == 2'b11) ||
                    (is_store && ex_funct3_i[2]);

`ifdef LSU_MISALIGN_TRAP_EN
  assign misalign = ((ex_funct3_i[1:0] == 2'b01) && ex_addr_i[0]) ||
                    ((ex_funct3_i[1:0] == 2'b10) && (ex_addr_i[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = ex_wdata_i;
    case (ex_funct3_i[1:0])
      2'b00: begin
        lane_be    = 4'b0001 << ex_addr_i[1:0];
        lane_wdata = {4{ex_wdata_i[7:0]}};
      end
      2'b01: begin
        lane_be    = 4'b0011 << {ex_addr_i[1], 1'b0};
        lane_wdata = {2{ex_wdata_i[15:0]}};
      end
      default: ;
    endcase
  end

  assign rd_byte = dmem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
  assign rd_half = addr_q[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];

  always_comb begin
    load_data = dmem_rdata_i;
    case (funct3_q)
      3'b000:  load_data = {{24{rd_byte[7]}}, rd_byte};
      3'b001:  load_data = {{16{rd_half[15]}}, rd_half};
      3'b100:  load_data = {24'b0, rd_byte};
      3'b101:  load_data = {16'b0, rd_half};
      default: load_data = dmem_rdata_i;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    we_d       = we_q;
    funct3_d   = funct3_q;
    rd_d       = rd_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_data_d  = wb_data_q;
    err_d      = 1'b0;
    err_addr_d = err_addr_q;

    ex_ready_o   = (state_q == StIdle) && (BYPASS_NONMEM || is_mem);
    dmem_req_o   = (state_q == StReq);
    dmem_we_o    = dmem_req_o & we_q;
    dmem_be_o    = dmem_req_o ? be_q : 4'b0000;
    dmem_addr_o  = dmem_req_o ? {addr_q[31:2], 2'b00} : 32'h0;
    dmem_wdata_o = dmem_req_o ? wdata_q : 32'h0;

    case (state_q)
      StIdle: begin
        if (ex_valid_i && ex_ready_o) begin
          if (!is_mem) begin
            wb_valid_d = 1'b1;
            wb_rd_d    = ex_rd_i;
            wb_data_d  = ex_addr_i;
          end else if (f3_rsvd || misalign) begin
            err_d      = 1'b1;
            err_addr_d = ex_addr_i;
          end else begin
            addr_d   = ex_addr_i;
            wdata_d  = is_store ? lane_wdata : 32'h0;
            be_d     = lane_be;
            we_d     = is_store;
            funct3_d = ex_funct3_i;
            rd_d     = ex_rd_i;
            cnt_d    = 8'd0;
            state_d  = StReq;
          end
        end
      end
      StReq: begin
        // A grant in the final allowed cycle still completes the access.
        if (dmem_gnt_i) begin
          cnt_d   = 8'd0;
          state_d = we_q ? StResp : StWaitR;
        end else if (cnt_q == TimeoutLast) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StWaitR: begin
        if (dmem_rvalid_i) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_data_d  = load_data;
          state_d    = StResp;
        end else if (cnt_q == TimeoutLast) begin
          err_d      = 1'b1;
          err_addr_d = addr_q;
          state_d    = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      StResp:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      be_q       <= 4'b0000;
      we_q       <= 1'b0;
      funct3_q   <= 3'b000;
      rd_q       <= 5'd0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_data_q  <= 32'h0;
      err_q      <= 1'b0;
      err_addr_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      we_q       <= we_d;
      funct3_q   <= funct3_d;
      rd_q       <= rd_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
      err_addr_q <= err_addr_d;
    end
  end

  assign wb_valid_o     = wb_valid_q;
  assign wb_rd_o        = wb_rd_q;
  assign wb_data_o      = wb_data_q;
  assign lsu_err_o      = err_q;
  assign lsu_err_addr_o = err_addr_q;

endmodule

// File: tb/tb_lsu_stage.sv
// Self-checking bench for lsu_stage: transaction-level model drives per-cycle expectations,
// one negedge compare process checks the DUT, plus directed literal checks.
module tb_lsu_stage;
  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_ready;
  logic [1:0]  ex_memop;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        dmem_req, dmem_we, dmem_gnt, dmem_rvalid;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic        wb_valid, lsu_err;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data, lsu_err_addr;

  always #5 clk = ~clk;

  lsu_stage #(.TIMEOUT(T), .BYPASS_NONMEM(1'b1)) dut (
    .clk_i(clk), .rst_i(rst),
    .ex_valid_i(ex_valid), .ex_ready_o(ex_ready), .ex_memop_i(ex_memop),
    .ex_funct3_i(ex_funct3), .ex_addr_i(ex_addr), .ex_wdata_i(ex_wdata), .ex_rd_i(ex_rd),
    .dmem_req_o(dmem_req), .dmem_we_o(dmem_we), .dmem_be_o(dmem_be), .dmem_addr_o(dmem_addr),
    .dmem_wdata_o(dmem_wdata), .dmem_gnt_i(dmem_gnt), .dmem_rvalid_i(dmem_rvalid),
    .dmem_rdata_i(dmem_rdata), .wb_valid_o(wb_valid), .wb_rd_o(wb_rd), .wb_data_o(wb_data),
    .lsu_err_o(lsu_err), .lsu_err_addr_o(lsu_err_addr)
  );

  int n_vec = 0;
  int n_bad = 0;
  logic chk = 1'b0;

  // Expected outputs for the current cycle.
  logic        e_rdy, e_req, e_we, e_wbv, e_err;
  logic [3:0]  e_be;
  logic [31:0] e_addr, e_wdata, e_wbd, e_erra;
  logic [4:0]  e_wbrd;
  // Pulses owed in the following cycle.
  logic        p_wb = 1'b0, p_err = 1'b0;
  logic [4:0]  p_rd;
  logic [31:0] p_wbd, p_erra;
  // Last values observed on the DUT, for directed literal checks.
  logic [31:0] l_addr, l_wdata, l_wbd, l_erra;
  logic [3:0]  l_be;
  logic [4:0]  l_wbrd;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      cmp("ex_ready", 32'(ex_ready), 32'(e_rdy));
      cmp("dmem_req", 32'(dmem_req), 32'(e_req));
      if (e_req) begin
        cmp("dmem_addr", dmem_addr, e_addr);
        cmp("dmem_be", 32'(dmem_be), 32'(e_be));
        cmp("dmem_we", 32'(dmem_we), 32'(e_we));
        if (e_we) cmp("dmem_wdata", dmem_wdata, e_wdata);
      end
      cmp("wb_valid", 32'(wb_valid), 32'(e_wbv));
      if (e_wbv) begin
        cmp("wb_rd", 32'(wb_rd), 32'(e_wbrd));
        cmp("wb_data", wb_data, e_wbd);
      end
      cmp("lsu_err", 32'(lsu_err), 32'(e_err));
      if (e_err) cmp("lsu_err_addr", lsu_err_addr, e_erra);
      if (dmem_req) begin
        l_addr = dmem_addr; l_be = dmem_be; l_wdata = dmem_wdata;
      end
      if (wb_valid) begin
        l_wbd = wb_data; l_wbrd = wb_rd;
      end
      if (lsu_err) l_erra = lsu_err_addr;
    end
  end

  task automatic cyc(input logic rdy, input logic req);
    e_rdy = rdy; e_req = req;
    e_wbv = p_wb; e_wbrd = p_rd; e_wbd = p_wbd;
    e_err = p_err; e_erra = p_erra;
    p_wb = 1'b0; p_err = 1'b0;
    chk = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic garbage();
    ex_valid = 1'($urandom); ex_memop = 2'($urandom); ex_funct3 = 3'($urandom);
    ex_addr = $urandom; ex_wdata = $urandom; ex_rd = 5'($urandom);
  endtask

  task automatic idle_cyc();
    garbage();
    ex_valid = 1'b0; dmem_gnt = 1'b0;
    dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
    cyc(1'b1, 1'b0);
  endtask

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] w,
                                             input logic [1:0] off);
    logic [31:0] b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (16 * off[1])) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 32'd128) ? b + 32'hFFFF_FF00 : b;
      3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  // g/r: cycles of delay before gnt/rvalid; a delay of T or more forces a timeout.
  task automatic do_op(input logic [1:0] memop, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int g,
                       input int r, input logic [31:0] rdat);
    logic is_mem, rsvd, mis, granted, got;
    int   sz;
    is_mem = (memop == 2'b01) || (memop == 2'b10);
    rsvd   = is_mem && ((f3 == 3'd3) || (f3 == 3'd6) || (f3 == 3'd7) ||
                        ((memop == 2'b10) && f3[2]));
    sz     = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
`ifdef LSU_MISALIGN_TRAP_EN
    mis = is_mem && (((sz == 2) && addr[0]) || ((sz == 4) && (addr[1:0] != 2'b00)));
`else
    mis = 1'b0;
`endif
    ex_valid = 1'b1; ex_memop = memop; ex_funct3 = f3;
    ex_addr = addr; ex_wdata = wdata; ex_rd = rd;
    dmem_gnt = 1'b0; dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
    cyc(1'b1, 1'b0);
    garbage();
    if (!is_mem) begin
      p_wb = 1'b1; p_rd = rd; p_wbd = addr;
      return;
    end
    if (rsvd || mis) begin
      p_err = 1'b1; p_erra = addr;
      return;
    end
    e_we    = (memop == 2'b10);
    e_addr  = addr & 32'hFFFF_FFFC;
    e_be    = (sz == 1) ? 4'(1 << addr[1:0]) : (sz == 2) ? 4'(3 << (addr[1:0] & 2'd2)) : 4'hF;
    e_wdata = (sz == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
              (sz == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    granted = 1'b0;
    for (int i = 1; i <= T; i++) begin
      dmem_gnt = (i == g + 1); dmem_rvalid = 1'b0;
      garbage();
      cyc(1'b0, 1'b1);
      if (i == g + 1) begin
        granted = 1'b1;
        break;
      end
    end
    dmem_gnt = 1'b0;
    if (!granted) begin
      p_err = 1'b1; p_erra = addr;
      return;
    end
    if (memop == 2'b01) begin
      got = 1'b0;
      for (int j = 1; j <= T; j++) begin
        dmem_rvalid = (j == r + 1);
        dmem_rdata  = (j == r + 1) ? rdat : $urandom;
        garbage();
        cyc(1'b0, 1'b0);
        if (j == r + 1) begin
          got = 1'b1;
          break;
        end
      end
      dmem_rvalid = 1'b0;
      if (!got) begin
        p_err = 1'b1; p_erra = addr;
        return;
      end
      p_wb = 1'b1; p_rd = rd; p_wbd = model_load(f3, rdat, addr[1:0]);
    end
    dmem_rvalid = 1'($urandom); dmem_rdata = $urandom;
    garbage();
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [2:0] legal_f3 [5];
    logic [1:0] mo;
    logic [2:0] f3;
    int         k;
    legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    rst = 1'b1; ex_valid = 1'b0; ex_memop = 2'b00; ex_funct3 = 3'b000;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'd0;
    dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    cmp("rst_wb_data", wb_data, 32'h0);
    cmp("rst_err_addr", lsu_err_addr, 32'h0);
    cmp("rst_dmem_addr", dmem_addr, 32'h0);
    idle_cyc();

    do_op(2'b01, 3'b010, 32'h0000_1000, 32'h0, 5'd5, 0, 0, 32'hDEAD_BEEF);
    idle_cyc();
    cmp("lw_addr", l_addr, 32'h0000_1000);
    cmp("lw_be", 32'(l_be), 32'hF);
    cmp("lw_data", l_wbd, 32'hDEAD_BEEF);

    do_op(2'b01, 3'b000, 32'h0000_1003, 32'h0, 5'd6, 0, 0, 32'h80FF_FFFF);
    idle_cyc();
    cmp("lb_be", 32'(l_be), 32'h8);
    cmp("lb_data", l_wbd, 32'hFFFF_FF80);

    do_op(2'b01, 3'b100, 32'h0000_1003, 32'h0, 5'd6, 0, 1, 32'h80FF_FFFF);
    idle_cyc();
    cmp("lbu_data", l_wbd, 32'h0000_0080);

    do_op(2'b10, 3'b000, 32'h0000_2002, 32'h0000_00A5, 5'd9, 3, 0, 32'h0);
    idle_cyc();
    cmp("sb_addr", l_addr, 32'h0000_2000);
    cmp("sb_be", 32'(l_be), 32'h4);
    cmp("sb_wdata", l_wdata, 32'hA5A5_A5A5);

    do_op(2'b01, 3'b001, 32'h0000_3001, 32'h0, 5'd2, 0, 0, 32'h1234_ABCD);
    idle_cyc();
`ifdef LSU_MISALIGN_TRAP_EN
    cmp("lh_mis_err_addr", l_erra, 32'h0000_3001);
`else
    cmp("lh_mis_addr", l_addr, 32'h0000_3000);
    cmp("lh_mis_data", l_wbd, 32'hFFFF_ABCD);
`endif

    do_op(2'b01, 3'b010, 32'h0000_4000, 32'h0, 5'd3, 9, 0, 32'h0);
    idle_cyc();
    cmp("tmo_err_addr", l_erra, 32'h0000_4000);

    do_op(2'b01, 3'b010, 32'h0000_5004, 32'h0, 5'd4, 3, 3, 32'hCAFE_F00D);
    idle_cyc();
    cmp("late_gnt_addr", l_addr, 32'h0000_5004);
    cmp("late_gnt_data", l_wbd, 32'hCAFE_F00D);

    do_op(2'b00, 3'b000, 32'h1234_5678, 32'h0, 5'd7, 0, 0, 32'h0);
    idle_cyc();
    cmp("bypass_rd", 32'(l_wbrd), 32'd7);
    cmp("bypass_data", l_wbd, 32'h1234_5678);

    do_op(2'b10, 3'b100, 32'h0000_6000, 32'h0, 5'd1, 0, 0, 32'h0);
    idle_cyc();
    cmp("rsvd_err_addr", l_erra, 32'h0000_6000);

    // Reset while waiting for read data; the late rvalid must be dropped.
    ex_valid = 1'b1; ex_memop = 2'b01; ex_funct3 = 3'b010;
    ex_addr = 32'h0000_7000; ex_rd = 5'd3; dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    cyc(1'b1, 1'b0);
    garbage();
    e_we = 1'b0; e_addr = 32'h0000_7000; e_be = 4'hF;
    dmem_gnt = 1'b1;
    cyc(1'b0, 1'b1);
    dmem_gnt = 1'b0; rst = 1'b1;
    cyc(1'b0, 1'b0);
    rst = 1'b0; ex_valid = 1'b0;
    cmp("rst_mid_wb_data", wb_data, 32'h0);
    cmp("rst_mid_err_addr", lsu_err_addr, 32'h0);
    cmp("rst_mid_wb_rd", 32'(wb_rd), 32'h0);
    dmem_rvalid = 1'b1; dmem_rdata = $urandom;
    cyc(1'b1, 1'b0);
    cyc(1'b1, 1'b0);
    dmem_rvalid = 1'b0;

    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 9);
      mo = (k < 4) ? 2'b01 : (k < 7) ? 2'b10 : (k < 9) ? 2'b00 : 2'b11;
      f3 = ($urandom_range(0, 9) < 7) ? legal_f3[$urandom_range(0, 4)] : 3'($urandom);
      do_op(mo, f3, $urandom, $urandom, 5'($urandom), $urandom_range(0, 5),
            $urandom_range(0, 5), $urandom);
      if ($urandom_range(0, 3) == 0) idle_cyc();
    end
    idle_cyc();
    idle_cyc();
    chk = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
